bip_pc_unit: RTL and testbench

Parametrised program-counter unit for the BIP processor, the next generation of the fetch-address register. It holds the instruction address presented to program memory and adds an explicit run/halt state machine, stall support, and a hardware return-address stack for subroutine calls and returns. It sits between the control unit, which supplies the control strobes and target address, and the program memory address port.

---
 rtl/bip_pc_unit.sv | 163 ++++++++++++++++
 tb/tb_bip_pc_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bip_pc_unit.sv
// bip_pc_unit: fetch-address register for the BIP processor.
// Holds the program-memory address and adds a run/halt state machine,
// stall support and a small hardware return-address stack for call/ret.
module bip_pc_unit #(
    parameter int              AB          = 11,
    parameter int              STACK_DEPTH = 4,
    parameter logic [AB-1:0]   RESET_ADDR  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_bip,
    input  logic          stall,
    input  logic          jmp,
    input  logic          call,
    input  logic          ret,
    input  logic          halt,
    input  logic [AB-1:0] target,
    output logic [AB-1:0] addr,
    output logic          running,
    output logic          halted,
    output logic          stack_empty,
    output logic          stack_full,
    output logic          stack_err
);

    // Stack pointer counts 0..STACK_DEPTH, so it needs one more code than
    // there are entries; the entry index only needs to cover the entries.
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [SPW-1:0] SP_ZERO = '0;
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [AB-1:0]  ADDR_ONE = AB'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [AB-1:0]  addr_q, addr_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;

    logic [AB-1:0]  stack_q [0:STACK_DEPTH-1];

    logic           pushEn;
    logic [AB-1:0]  pushData;
    logic [IW-1:0]  pushIdx;
    logic [IW-1:0]  popIdx;
    logic [SPW-1:0] spDec;
    logic [AB-1:0]  addrInc;
    logic           isEmpty;
    logic           isFull;

    // Shared arithmetic: the incremented address wraps naturally at AB bits,
    // which also gives the wrapped push value for a call at the top address.
    always_comb begin
        addrInc  = addr_q + ADDR_ONE;
        spDec    = sp_q - SP_ONE;
        pushIdx  = sp_q[IW-1:0];
        popIdx   = spDec[IW-1:0];
        isEmpty  = (sp_q == SP_ZERO);
        isFull   = (sp_q == SP_FULL);
        pushData = addrInc;
    end

    // Next-state decode: one action per unstalled RUN cycle, chosen by the
    // fixed priority halt > ret > call > jmp > increment.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sp_d    = sp_q;
        err_d   = err_q;
        pushEn  = 1'b0;

        case (state_q)
            IDLE: begin
                // The first fetch after start is RESET_ADDR itself.
                addr_d = RESET_ADDR;
                if (start_bip) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (ret) begin
                        if (!isEmpty) begin
                            addr_d = stack_q[popIdx];
                            sp_d   = spDec;
                        end else begin
                            addr_d = addrInc;
                            err_d  = 1'b1;
                        end
                    end else if (call) begin
                        if (!isFull) begin
                            pushEn = 1'b1;
                            addr_d = target;
                            sp_d   = sp_q + SP_ONE;
                        end else begin
                            addr_d = addrInc;
                            err_d  = 1'b1;
                        end
                    end else if (jmp) begin
                        addr_d = target;
                    end else begin
                        addr_d = addrInc;
                    end
                end
            end

            HALTED: begin
                // Resume just past the instruction that halted.
                if (start_bip) begin
                    state_d = RUN;
                    addr_d  = addrInc;
                end
            end

            default: begin
                state_d = IDLE;
                addr_d  = RESET_ADDR;
            end
        endcase
    end

    // Control registers; reset wins over every strobe and drops the stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= RESET_ADDR;
            sp_q    <= SP_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; entries keep their contents through reset,
    // only the pointer is cleared, so no reset branch here.
    always_ff @(posedge clk) begin
        if (pushEn && !rst) begin
            stack_q[pushIdx] <= pushData;
        end
    end

    // Outputs are straight decodes of the registered state.
    always_comb begin
        addr        = addr_q;
        running     = (state_q == RUN);
        halted      = (state_q == HALTED);
        stack_empty = isEmpty;
        stack_full  = isFull;
        stack_err   = err_q;
    end

endmodule

// File: tb/tb_bip_pc_unit.sv
// Directed bench for bip_pc_unit with a queue scoreboard: every step pushes
// its hand-derived expected address and flags, and the check pops them after
// the clock edge that should have produced them.
module tb_bip_pc_unit;

   localparam int AB = 11;

   // Strobe masks, packed {rst,start,stall,jmp,call,ret,halt}
   localparam logic [6:0] S_NONE  = 7'b0000000;
   localparam logic [6:0] S_RST   = 7'b1000000;
   localparam logic [6:0] S_START = 7'b0100000;
   localparam logic [6:0] S_STALL = 7'b0010000;
   localparam logic [6:0] S_JMP   = 7'b0001000;
   localparam logic [6:0] S_CALL  = 7'b0000100;
   localparam logic [6:0] S_RET   = 7'b0000010;
   localparam logic [6:0] S_HALT  = 7'b0000001;

   // Flag masks, packed {running,halted,stack_empty,stack_full,stack_err}
   localparam logic [4:0] F_RUN   = 5'b10000;
   localparam logic [4:0] F_HALT  = 5'b01000;
   localparam logic [4:0] F_EMPTY = 5'b00100;
   localparam logic [4:0] F_FULL  = 5'b00010;
   localparam logic [4:0] F_ERR   = 5'b00001;

   typedef struct {
      string         tag;
      logic [AB-1:0] addr;
      logic [4:0]    flags;
   } expT;

   logic          clock;
   logic          reset;
   logic          startBip;
   logic          stall;
   logic          jmp;
   logic          call;
   logic          ret;
   logic          halt;
   logic [AB-1:0] target;
   logic [AB-1:0] addr;
   logic          running;
   logic          halted;
   logic          stackEmpty;
   logic          stackFull;
   logic          stackErr;

   expT scoreboard[$];
   int  total = 0;
   int  bad   = 0;

   bip_pc_unit #(
      .AB(AB),
      .STACK_DEPTH(4),
      .RESET_ADDR('0)
   ) dut (
      .clk(clock),
      .rst(reset),
      .start_bip(startBip),
      .stall(stall),
      .jmp(jmp),
      .call(call),
      .ret(ret),
      .halt(halt),
      .target(target),
      .addr(addr),
      .running(running),
      .halted(halted),
      .stack_empty(stackEmpty),
      .stack_full(stackFull),
      .stack_err(stackErr)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of strobes on the falling edge and record what the
   // outputs must look like after the following rising edge.
   task automatic applyStimulus(input string tag, input logic [6:0] strobes,
                                input logic [AB-1:0] tgt,
                                input logic [AB-1:0] expAddr,
                                input logic [4:0] expFlags);
      expT e;
      @(negedge clock);
      reset    = strobes[6];
      startBip = strobes[5];
      stall    = strobes[4];
      jmp      = strobes[3];
      call     = strobes[2];
      ret      = strobes[1];
      halt     = strobes[0];
      target   = tgt;
      e.tag    = tag;
      e.addr   = expAddr;
      e.flags  = expFlags;
      scoreboard.push_back(e);
   endtask

   // Wait for the edge, then pop the oldest expectation and compare.
   task automatic checkOutput();
      expT        e;
      logic [4:0] obsFlags;
      @(posedge clock);
      #1;
      total++;
      assert (scoreboard.size() != 0)
      else begin
         bad++;
         $error("[TB] FAIL scoreboard: observed=empty expected=entry");
         return;
      end
      e = scoreboard.pop_front();
      obsFlags = {running, halted, stackEmpty, stackFull, stackErr};
      assert (addr === e.addr)
      else begin
         bad++;
         $error("[TB] FAIL %s.addr: observed=%03h expected=%03h", e.tag, addr, e.addr);
      end
      total++;
      assert (obsFlags === e.flags)
      else begin
         bad++;
         $error("[TB] FAIL %s.flags: observed=%05b expected=%05b", e.tag, obsFlags, e.flags);
      end
   endtask

   task automatic step(input string tag, input logic [6:0] strobes,
                       input logic [AB-1:0] tgt, input logic [AB-1:0] expAddr,
                       input logic [4:0] expFlags);
      applyStimulus(tag, strobes, tgt, expAddr, expFlags);
      checkOutput();
   endtask

   // Directed sequence; expected values are worked out by hand per step.
   initial begin
      reset    = 1'b0;
      startBip = 1'b0;
      stall    = 1'b0;
      jmp      = 1'b0;
      call     = 1'b0;
      ret      = 1'b0;
      halt     = 1'b0;
      target   = '0;
      $display("[TB] starting bip_pc_unit bench");

      // Reset and start
      step("rst0",   S_RST,   11'h000, 11'h000, F_EMPTY);
      step("rst1",   S_RST,   11'h000, 11'h000, F_EMPTY);
      step("start",  S_START, 11'h000, 11'h000, F_RUN | F_EMPTY);
      step("inc1",   S_NONE,  11'h000, 11'h001, F_RUN | F_EMPTY);
      step("inc2",   S_NONE,  11'h000, 11'h002, F_RUN | F_EMPTY);
      step("inc3",   S_NONE,  11'h000, 11'h003, F_RUN | F_EMPTY);

      // Call and return from address 5
      step("inc4",   S_NONE,  11'h000, 11'h004, F_RUN | F_EMPTY);
      step("inc5",   S_NONE,  11'h000, 11'h005, F_RUN | F_EMPTY);
      step("call",   S_CALL,  11'h100, 11'h100, F_RUN);
      step("sub1",   S_NONE,  11'h000, 11'h101, F_RUN);
      step("sub2",   S_NONE,  11'h000, 11'h102, F_RUN);
      step("ret",    S_RET,   11'h000, 11'h006, F_RUN | F_EMPTY);

      // Halt, hold, resume, stall
      step("jmp20",  S_JMP,   11'h020, 11'h020, F_RUN | F_EMPTY);
      step("halt",   S_HALT,  11'h000, 11'h020, F_HALT | F_EMPTY);
      for (int i = 0; i < 10; i++) begin
         step("hold", (i % 2 == 0) ? S_NONE : S_JMP, 11'h3AA, 11'h020, F_HALT | F_EMPTY);
      end
      step("resume", S_START, 11'h000, 11'h021, F_RUN | F_EMPTY);
      step("stjmp",  S_STALL | S_JMP,  11'h7FF, 11'h021, F_RUN | F_EMPTY);
      step("sthalt", S_STALL | S_HALT, 11'h000, 11'h021, F_RUN | F_EMPTY);

      // Wrap and priority, including a push of the wrapped address
      step("jmp7ff", S_JMP,   11'h7FF, 11'h7FF, F_RUN | F_EMPTY);
      step("wrap",   S_NONE,  11'h000, 11'h000, F_RUN | F_EMPTY);
      step("callA",  S_CALL,  11'h7FF, 11'h7FF, F_RUN);
      step("callW",  S_CALL,  11'h030, 11'h030, F_RUN);
      step("prio",   S_HALT | S_CALL | S_JMP, 11'h055, 11'h030, F_HALT);
      step("resum2", S_START, 11'h000, 11'h031, F_RUN);
      step("retW",   S_RET,   11'h000, 11'h000, F_RUN);
      step("retA",   S_RET,   11'h000, 11'h001, F_RUN | F_EMPTY);

      // Overflow: four nested calls fill the stack, the fifth fails
      step("nest1",  S_CALL,  11'h200, 11'h200, F_RUN);
      step("nest2",  S_CALL,  11'h300, 11'h300, F_RUN);
      step("nest3",  S_CALL,  11'h400, 11'h400, F_RUN);
      step("nest4",  S_CALL,  11'h500, 11'h500, F_RUN | F_FULL);
      step("nest5",  S_CALL,  11'h600, 11'h501, F_RUN | F_FULL | F_ERR);
      step("retOv",  S_RET,   11'h000, 11'h401, F_RUN | F_ERR);
      step("startR", S_START, 11'h000, 11'h402, F_RUN | F_ERR);

      // Reset mid-call; call with target equal to addr
      step("rstA",   S_RST,   11'h000, 11'h000, F_EMPTY);
      step("startA", S_START, 11'h000, 11'h000, F_RUN | F_EMPTY);
      step("callB",  S_CALL,  11'h010, 11'h010, F_RUN);
      step("callS",  S_CALL,  11'h010, 11'h010, F_RUN);
      step("retS",   S_RET,   11'h000, 11'h011, F_RUN);
      step("callC",  S_CALL,  11'h040, 11'h040, F_RUN);
      step("rstMid", S_RST | S_CALL, 11'h050, 11'h000, F_EMPTY);
      step("idleJ",  S_JMP,   11'h123, 11'h000, F_EMPTY);

      // Underflow from an empty stack, then the flag stays sticky
      step("startU", S_START, 11'h000, 11'h000, F_RUN | F_EMPTY);
      step("retU",   S_RET,   11'h000, 11'h001, F_RUN | F_EMPTY | F_ERR);
      step("callU",  S_CALL,  11'h050, 11'h050, F_RUN | F_ERR);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
